ordena_n_num: RTL and testbench
===============================

ORDENA_N_NUM -- requirements
Module: ordena_n_num

Interface
REQ-001 The module SHALL have parameter WIDTH, default 9, giving the bit width of each unsigned element.
REQ-002 The module SHALL have parameter N, default 8, giving the element count; legal range 2..64.
REQ-003 The module SHALL have parameter DESC, default 0; 0 sorts ascending, 1 sorts descending.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit: request to sort din, sampled in IDLE only.
REQ-007 The module SHALL have port din, input, N*WIDTH bits: unsorted vector; element i = din[i*WIDTH +: WIDTH].
REQ-008 The module SHALL have port busy, output, 1 bit: high while sorting (SORT state).
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking dout newly valid.
REQ-010 The module SHALL have port dout, output, N*WIDTH bits: sorted vector, same element indexing as din.

Function
REQ-011 The block SHALL implement FSM states IDLE, SORT and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL copy din into an internal N-element work array, clear phase counter ph, and enter SORT.
REQ-013 In SORT, each cycle SHALL perform one odd-even transposition phase on the work array:
- ph even: compare-exchange pairs (0,1),(2,3),...
- ph odd: compare-exchange pairs (1,2),(3,4),...
- any element without a partner (N odd/even edge) is unchanged.
REQ-014 Compare-exchange SHALL swap a pair (j,j+1) only when a[j]>a[j+1] (DESC=0) or a[j]<a[j+1] (DESC=1); equal values are never swapped.
REQ-015 Comparisons SHALL be unsigned over full WIDTH, with no truncation or extension.
REQ-016 SORT SHALL last exactly N cycles (ph = 0..N-1), with no early termination.
REQ-017 On the edge completing phase N-1, the block SHALL load the result into dout and enter DONE.
REQ-018 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+N.
REQ-019 DONE SHALL last one cycle, with done=1, and return to IDLE.
REQ-020 busy SHALL be 1 exactly in SORT, and done SHALL be 1 exactly in DONE.
REQ-021 start SHALL be ignored in SORT and DONE; no queuing, and the current sort is not restarted.
REQ-022 din SHALL be sampled only on the accepting edge; later changes to din SHALL NOT affect the running sort.
REQ-023 dout SHALL change only on entry to DONE, and SHALL hold its value otherwise, including across later sorts until their completion.
REQ-024 A start held high continuously SHALL produce back-to-back sorts, each starting N+2 cycles apart (IDLE, SORT x N, DONE).

Reset
REQ-025 With rst=1 at a rising edge, state SHALL become IDLE and busy, done, dout and ph SHALL all be 0.
REQ-026 rst SHALL take priority over start and over any in-progress SORT or DONE; a sort interrupted by reset produces no done pulse and no dout update.
REQ-027 The first edge with rst=0 and start=1 SHALL accept a new sort normally.

Verification (N=4, WIDTH=9 unless stated; list element 0 first)
REQ-028 din={3,1,4,2}, start pulse in IDLE -> busy for 4 cycles, done on the 5th cycle after the accepting edge, dout={1,2,3,4}.
REQ-029 DESC=1, din={3,1,4,2} -> dout={4,3,2,1} with the same latency.
REQ-030 din={1,1,1,1} -> dout={1,1,1,1}, full 4-cycle SORT, done exactly once.
REQ-031 din={511,0,511,0} -> dout={0,0,511,511}, confirming full-width unsigned compare; N=5, din={5,4,3,2,1} -> dout={1,2,3,4,5} (odd N).
REQ-032 Start pulse at SORT cycle 2 with different din -> ignored; first result only; din changes mid-sort do not alter dout.
REQ-033 rst asserted in SORT cycle 2 -> next cycle busy=0, done=0, dout=0; no done pulse follows; a subsequent start sorts correctly.

Source files
------------

// File: rtl/ordena_n_num.sv
// Odd-even transposition sorter: one compare-exchange phase per clock over an
// N-element work array, N phases per sort, result published with a done pulse.
module ordena_n_num #(
  parameter int WIDTH = 9,
  parameter int N     = 8,
  parameter int DESC  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*WIDTH-1:0] din,
  output logic               busy,
  output logic               done,
  output logic [N*WIDTH-1:0] dout
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] PH_LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    ph_q;
  logic [WIDTH-1:0] work_q [N];
  logic [WIDTH-1:0] work_d [N];
  logic             last_phase;

  assign last_phase = (ph_q == PH_LAST);

  // True when the pair must be exchanged; equal values never swap, which
  // keeps the network stable.
  function automatic logic out_of_order(input logic [WIDTH-1:0] lo,
                                        input logic [WIDTH-1:0] hi);
    return (DESC != 0) ? (lo < hi) : (lo > hi);
  endfunction

  // One transposition phase: even ph pairs (0,1),(2,3)..., odd ph pairs
  // (1,2),(3,4)...; pairs never overlap, so all read the registered array.
  always_comb begin : phase_net
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would infer a latch.
    work_d = work_q;
    for (int j = 0; j < N - 1; j++) begin
      if (j[0] == ph_q[0] && out_of_order(work_q[j], work_q[j+1])) begin
        work_d[j]   = work_q[j+1];
        work_d[j+1] = work_q[j];
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = SORT;
      SORT: begin
        busy = 1'b1;
        if (last_phase) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : ctrl_regs
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        ph_q <= '0;
      end else if (state_q == SORT) begin
        ph_q <= ph_q + 1'b1;
        if (last_phase) begin
          for (int i = 0; i < N; i++) dout[i*WIDTH +: WIDTH] <= work_d[i];
        end
      end
    end
  end

  // NOTE: the work array has no reset; it is always loaded from din before
  // SORT reads it, and a load during reset is harmless since state stays IDLE.
  always_ff @(posedge clk) begin : work_regs
    if (state_q == IDLE && start) begin
      for (int i = 0; i < N; i++) work_q[i] <= din[i*WIDTH +: WIDTH];
    end else if (state_q == SORT) begin
      work_q <= work_d;
    end
  end

endmodule

// File: tb/tb_ordena_n_num.sv
// Directed bench for ordena_n_num: N=4 ascending, N=4 descending and N=5
// ascending instances share clk/rst/start; expected vectors are hand-sorted.
module tb_ordena_n_num;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [35:0] din4;
  logic [44:0] din5;

  logic        busy_a, done_a, busy_d, done_d, busy_o, done_o;
  logic [35:0] dout_a, dout_d;
  logic [44:0] dout_o;

  logic [35:0] prev_a, prev_d;
  logic [44:0] prev_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ordena_n_num #(.WIDTH(9), .N(4), .DESC(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .din(din4),
    .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  ordena_n_num #(.WIDTH(9), .N(4), .DESC(1)) dut_d (
    .clk(clk), .rst(rst), .start(start), .din(din4),
    .busy(busy_d), .done(done_d), .dout(dout_d)
  );

  ordena_n_num #(.WIDTH(9), .N(5), .DESC(0)) dut_o (
    .clk(clk), .rst(rst), .start(start), .din(din5),
    .busy(busy_o), .done(done_o), .dout(dout_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [35:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {9'(e3), 9'(e2), 9'(e1), 9'(e0)};
  endfunction

  function automatic logic [44:0] pack5(input int e0, input int e1, input int e2,
                                        input int e3, input int e4);
    return {9'(e4), 9'(e3), 9'(e2), 9'(e1), 9'(e0)};
  endfunction

  // Cycle c is sampled on the falling edge after accept edge k + c - 1.
  task automatic run_sort(input string tag, input logic [35:0] d4, input logic [44:0] d5,
                          input logic [35:0] ea, input logic [35:0] ed,
                          input logic [44:0] eo, input bit mid_start);
    @(negedge clk);
    start = 1'b1;
    din4  = d4;
    din5  = d5;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (mid_start && c == 2) begin
        start = 1'b1;
        din4  = pack4(9, 9, 9, 9);
        din5  = pack5(8, 8, 8, 8, 8);
      end
      if (mid_start && c == 3) start = 1'b0;
      check($sformatf("%s.c%0d.busy_a", tag, c), 64'(busy_a), 64'(c <= 4));
      check($sformatf("%s.c%0d.done_a", tag, c), 64'(done_a), 64'(c == 5));
      check($sformatf("%s.c%0d.busy_d", tag, c), 64'(busy_d), 64'(c <= 4));
      check($sformatf("%s.c%0d.done_d", tag, c), 64'(done_d), 64'(c == 5));
      check($sformatf("%s.c%0d.busy_o", tag, c), 64'(busy_o), 64'(c <= 5));
      check($sformatf("%s.c%0d.done_o", tag, c), 64'(done_o), 64'(c == 6));
      check($sformatf("%s.c%0d.dout_a", tag, c), 64'(dout_a), 64'((c >= 5) ? ea : prev_a));
      check($sformatf("%s.c%0d.dout_d", tag, c), 64'(dout_d), 64'((c >= 5) ? ed : prev_d));
      check($sformatf("%s.c%0d.dout_o", tag, c), 64'(dout_o), 64'((c >= 6) ? eo : prev_o));
    end
    prev_a = ea;
    prev_d = ed;
    prev_o = eo;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy_a"}, 64'(busy_a), 64'd0);
    check({tag, ".done_a"}, 64'(done_a), 64'd0);
    check({tag, ".dout_a"}, 64'(dout_a), 64'd0);
    check({tag, ".busy_d"}, 64'(busy_d), 64'd0);
    check({tag, ".done_d"}, 64'(done_d), 64'd0);
    check({tag, ".dout_d"}, 64'(dout_d), 64'd0);
    check({tag, ".busy_o"}, 64'(busy_o), 64'd0);
    check({tag, ".done_o"}, 64'(done_o), 64'd0);
    check({tag, ".dout_o"}, 64'(dout_o), 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    din4  = '0;
    din5  = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst    = 1'b0;
    prev_a = '0;
    prev_d = '0;
    prev_o = '0;

    run_sort("basic", pack4(3, 1, 4, 2), pack5(5, 4, 3, 2, 1),
             pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), pack5(1, 2, 3, 4, 5), 1'b0);
    run_sort("equal", pack4(1, 1, 1, 1), pack5(1, 1, 1, 1, 1),
             pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack5(1, 1, 1, 1, 1), 1'b0);
    run_sort("fullw", pack4(511, 0, 511, 0), pack5(0, 511, 256, 1, 510),
             pack4(0, 0, 511, 511), pack4(511, 511, 0, 0), pack5(0, 1, 256, 510, 511), 1'b0);
    run_sort("midstart", pack4(7, 5, 6, 4), pack5(9, 8, 7, 6, 5),
             pack4(4, 5, 6, 7), pack4(7, 6, 5, 4), pack5(5, 6, 7, 8, 9), 1'b1);

    // Start held high: N=4 sorts restart every N+2 = 6 cycles.
    @(negedge clk);
    start = 1'b1;
    din4  = pack4(3, 1, 4, 2);
    din5  = pack5(5, 4, 3, 2, 1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("b2b.c%0d.done_a", c), 64'(done_a), 64'(c == 5 || c == 11));
      check($sformatf("b2b.c%0d.busy_a", c), 64'(busy_a),
            64'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
      check($sformatf("b2b.c%0d.done_d", c), 64'(done_d), 64'(c == 5 || c == 11));
    end
    start = 1'b0;
    check("b2b.dout_a", 64'(dout_a), 64'(pack4(1, 2, 3, 4)));
    check("b2b.dout_d", 64'(dout_d), 64'(pack4(4, 3, 2, 1)));
    repeat (10) @(negedge clk);
    check("b2b.dout_o", 64'(dout_o), 64'(pack5(1, 2, 3, 4, 5)));
    prev_a = pack4(1, 2, 3, 4);
    prev_d = pack4(4, 3, 2, 1);
    prev_o = pack5(1, 2, 3, 4, 5);

    // Reset during SORT cycle 2 aborts the sort with no done pulse.
    @(negedge clk);
    start = 1'b1;
    din4  = pack4(3, 1, 4, 2);
    din5  = pack5(5, 4, 3, 2, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midrst");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("midrst.c%0d.done_a", c), 64'(done_a), 64'd0);
      check($sformatf("midrst.c%0d.done_d", c), 64'(done_d), 64'd0);
      check($sformatf("midrst.c%0d.done_o", c), 64'(done_o), 64'd0);
    end
    prev_a = '0;
    prev_d = '0;
    prev_o = '0;

    run_sort("postrst", pack4(2, 3, 1, 0), pack5(4, 0, 3, 1, 2),
             pack4(0, 1, 2, 3), pack4(3, 2, 1, 0), pack5(0, 1, 2, 3, 4), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
